// File: rtl/neopixel_frame_scheduler.sv
// Double-buffered pixel frame store and refresh scheduler feeding neopixel_driver.
// Optional global brightness scaling on the read path: define NEOPIXEL_BRIGHTNESS_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a refresh tick; start pulse and bank swap issue here
// WAIT_BUSY  | start issued, waiting up to START_TMO cycles for driver busy
// SEND       | driver streaming the front bank, waiting for frame-done
// DRAIN      | frame counted, waiting for driver busy to drop
module neopixel_frame_scheduler #(
    parameter int  LEDS      = 200,
    parameter int  CLK_HZ    = 50_000_000,
    parameter int  FRAME_HZ  = 60,
    parameter int  START_TMO = 4,
    localparam int AW        = $clog2(LEDS * 3)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_commit,
    input  logic          i_enable,
    input  logic [7:0]    i_brightness,
    output logic          o_drv_start,
    input  logic          i_drv_busy,
    input  logic          i_drv_frame_done,
    input  logic [AW-1:0] i_drv_rd_addr,
    output logic [7:0]    o_drv_data,
    output logic          o_front_bank,
    output logic          o_swap_pending,
    output logic [15:0]   o_frame_cnt,
    output logic          o_err
);

    localparam int DEPTH     = LEDS * 3;
    localparam int FRAME_TCK = CLK_HZ / FRAME_HZ;
    localparam int TW        = (FRAME_TCK > 1) ? $clog2(FRAME_TCK) : 1;
    localparam int CW        = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    localparam logic [TW-1:0] TICK_LOAD = TW'(FRAME_TCK - 1);
    localparam logic [CW-1:0] TMO_LOAD  = CW'(START_TMO - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic            tick_q;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic            swap_q, swap_d;
    logic            bank_q, bank_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q;

    logic            tick_clr;
    logic            apply_swap;
    logic            tmo_err;
    logic            commit_err;
    logic            frame_inc;

    logic [7:0]      mem [0:2*DEPTH-1];
    logic [7:0]      ram_q;
    logic [AW:0]     wr_idx, rd_idx;
    logic            wr_ok, rd_ok;

    // Bank b occupies mem[b*DEPTH +: DEPTH]; writes always target the bank not on display.
    assign wr_ok  = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W);
    assign rd_ok  = {1'b0, i_drv_rd_addr} < DEPTH_W;
    assign wr_idx = {1'b0, i_wr_addr} + (bank_q ? '0 : DEPTH_W);
    assign rd_idx = {1'b0, i_drv_rd_addr} + (bank_q ? DEPTH_W : '0);

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ram_q <= 8'h00;
        end else begin
            ram_q <= rd_ok ? mem[rd_idx] : 8'h00;
        end
    end

`ifdef NEOPIXEL_BRIGHTNESS_EN
    assign o_drv_data = 8'(({9'd0, ram_q} * ({9'd0, i_brightness} + 17'd1)) >> 8);
`else
    logic brightness_unused;
    assign brightness_unused = ^i_brightness;
    assign o_drv_data        = ram_q;
`endif

    // A tick landing on the same edge as a start stays pending for the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q <= TICK_LOAD;
            tick_q  <= 1'b0;
        end else if (!i_enable) begin
            timer_q <= TICK_LOAD;
            tick_q  <= 1'b0;
        end else begin
            timer_q <= (timer_q == '0) ? TICK_LOAD : timer_q - TW'(1);
            tick_q  <= (timer_q == '0) | (tick_q & ~tick_clr);
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        start_d    = 1'b0;
        tick_clr   = 1'b0;
        apply_swap = 1'b0;
        tmo_err    = 1'b0;
        frame_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick_q && i_enable) begin
                    start_d    = 1'b1;
                    tick_clr   = 1'b1;
                    apply_swap = swap_q;
                    tmo_d      = TMO_LOAD;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (i_drv_busy) begin
                    state_d = ST_SEND;
                end else if (tmo_q == '0) begin
                    tmo_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - CW'(1);
                end
            end
            ST_SEND: begin
                if (i_drv_frame_done) begin
                    frame_inc = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!i_drv_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A commit on the swap edge itself belongs to the next frame, so it is not an overrun.
        commit_err = i_commit & swap_q & ~apply_swap;
        swap_d     = (swap_q & ~apply_swap) | i_commit;
        bank_d     = bank_q ^ apply_swap;
        err_d      = tmo_err | commit_err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            swap_q  <= 1'b0;
            bank_q  <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            swap_q  <= swap_d;
            bank_q  <= bank_d;
            start_q <= start_d;
            err_q   <= err_d;
            if (frame_inc) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign o_drv_start    = start_q;
    assign o_err          = err_q;
    assign o_front_bank   = bank_q;
    assign o_swap_pending = swap_q;
    assign o_frame_cnt    = cnt_q;

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// Randomized bench for neopixel_frame_scheduler: a frame-level reference model predicts
// every output each cycle while a small driver model answers start pulses.
module tb_neopixel_frame_scheduler;

    localparam int LEDS      = 8;
    localparam int CLK_HZ    = 60_000;
    localparam int FRAME_HZ  = 60;
    localparam int START_TMO = 4;
    localparam int FRAME_TCK = CLK_HZ / FRAME_HZ;
    localparam int DEPTH     = LEDS * 3;
    localparam int AW        = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          commit;
    logic          enable;
    logic [7:0]    brightness;
    logic          drv_start;
    logic          drv_busy;
    logic          drv_done;
    logic [AW-1:0] rd_addr;
    logic [7:0]    drv_data;
    logic          front_bank;
    logic          swap_pending;
    logic [15:0]   frame_cnt;
    logic          err;

    neopixel_frame_scheduler #(
        .LEDS(LEDS), .CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ), .START_TMO(START_TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_commit(commit), .i_enable(enable), .i_brightness(brightness),
        .o_drv_start(drv_start), .i_drv_busy(drv_busy), .i_drv_frame_done(drv_done),
        .i_drv_rd_addr(rd_addr), .o_drv_data(drv_data), .o_front_bank(front_bank),
        .o_swap_pending(swap_pending), .o_frame_cnt(frame_cnt), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: frame store contents, displayed bank, pending swap, frame progress
    logic [7:0] m_mem   [2][DEPTH];
    bit         m_valid [2][DEPTH];
    bit         m_front, m_swap, m_tick;
    int         m_phase;            // 0 idle, 1 awaiting busy, 2 sending, 3 draining
    int         m_wait, m_pos, m_cnt;
    bit         e_start, e_err, e_dvalid;
    logic [7:0] e_data;

    // host stimulus
    bit          h_rst, h_rand, h_wr_en, h_commit, h_enable;
    logic [AW-1:0] h_wr_addr;
    logic [7:0]  h_wr_data, h_br;

    // driver model
    int d_st, d_cnt;
    bit d_nobusy, d_force0, d_busy, d_done;

    int last_start  = -1;
    int start_seen  = 0;
    int err_seen    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_front  = 0;
        m_swap   = 0;
        m_tick   = 0;
        m_phase  = 0;
        m_wait   = 0;
        m_pos    = 0;
        m_cnt    = 0;
        e_start  = 0;
        e_err    = 0;
        e_data   = 8'h00;
        e_dvalid = 1;
    endtask

    task automatic model_edge();
        bit applied;
        int p;
        if (rst) begin
            model_reset();
        end else begin
            e_dvalid = m_valid[m_front][rd_addr];
`ifdef NEOPIXEL_BRIGHTNESS_EN
            p = (int'(m_mem[m_front][rd_addr]) * (int'(brightness) + 1)) / 256;
`else
            p = int'(m_mem[m_front][rd_addr]);
`endif
            e_data = 8'(p);
            if (wr_en && int'(wr_addr) < DEPTH) begin
                m_mem[!m_front][wr_addr]   = wr_data;
                m_valid[!m_front][wr_addr] = 1;
            end
            e_start = 0;
            e_err   = 0;
            case (m_phase)
                0: if (m_tick && enable) begin
                    e_start = 1;
                    m_phase = 1;
                    m_wait  = START_TMO;
                end
                1: if (drv_busy) m_phase = 2;
                   else begin
                       m_wait--;
                       if (m_wait == 0) begin
                           e_err   = 1;
                           m_phase = 0;
                       end
                   end
                2: if (drv_done) begin
                    m_cnt   = (m_cnt + 1) % 65536;
                    m_phase = 3;
                end
                default: if (!drv_busy) m_phase = 0;
            endcase
            applied = e_start && m_swap;
            if (commit && m_swap && !applied) e_err = 1;
            m_swap = (m_swap && !applied) || commit;
            if (applied) m_front = !m_front;
            if (!enable) begin
                m_tick = 0;
                m_pos  = 0;
            end else begin
                m_tick = (m_pos == FRAME_TCK - 1) || (m_tick && !e_start);
                m_pos  = (m_pos + 1) % FRAME_TCK;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_eq("start", drv_start, e_start);
        check_eq("err", err, e_err);
        check_eq("front", front_bank, m_front);
        check_eq("swap_pend", swap_pending, m_swap);
        check_eq("frame_cnt", frame_cnt, 32'(m_cnt));
        if (e_dvalid) check_eq("data", drv_data, e_data);
        if (drv_start) begin
            if (last_start >= 0) check_eq("period", 32'(cyc - last_start), FRAME_TCK);
            last_start = cyc;
            start_seen++;
        end
        if (err) err_seen++;

        if (h_rst) begin
            d_st = 0; d_busy = 0; d_done = 0;
        end else begin
            if (d_st == 0 && drv_start) begin
                if (d_nobusy) d_nobusy = 0;
                else begin
                    d_st  = 1;
                    d_cnt = $urandom_range(0, 2);
                end
            end
            if (d_st == 1) begin
                if (d_cnt == 0) begin d_busy = 1; d_st = 2; d_cnt = $urandom_range(5, 40); end
                else d_cnt--;
            end else if (d_st == 2) begin
                if (d_cnt == 0) begin d_done = 1; d_st = 3; d_cnt = 2; end
                else d_cnt--;
            end else if (d_st == 3) begin
                if (d_cnt == 0) begin d_done = 0; d_busy = 0; d_st = 0; end
                else d_cnt--;
            end
        end

        if (h_rand) begin
            h_wr_en   = ($urandom_range(0, 9) < 3);
            h_wr_addr = AW'($urandom_range(0, 31));
            h_wr_data = 8'($urandom);
            h_commit  = ($urandom_range(0, 399) == 0);
            h_br      = 8'($urandom);
        end

        rst        = h_rst;
        wr_en      = h_wr_en;
        wr_addr    = h_wr_addr;
        wr_data    = h_wr_data;
        commit     = h_commit;
        enable     = h_enable;
        brightness = h_br;
        drv_busy   = d_busy;
        drv_done   = d_done;
        rd_addr    = d_force0 ? '0 : AW'($urandom_range(0, DEPTH - 1));
        if (h_rst || !h_enable) last_start = -1;

        model_edge();

        if (!h_rand) begin
            h_wr_en  = 0;
            h_commit = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n && errors <= 40; i++) step();
    endtask

    task automatic wait_phase(input int ph, input int lim, input string tag);
        int n = 0;
        while (m_phase != ph && n < lim && errors <= 40) begin step(); n++; end
        check_eq(tag, 32'(m_phase), 32'(ph));
    endtask

    task automatic wait_start(input int lim, input string tag);
        int n0 = start_seen;
        int n  = 0;
        while (start_seen == n0 && n < lim && errors <= 40) begin step(); n++; end
        check_eq(tag, 32'(start_seen - n0), 1);
    endtask

    initial begin
        int c0, sc, n, f0, fc0, e0;
        bit held;

        h_rst = 1; h_rand = 0; h_wr_en = 0; h_commit = 0; h_enable = 0;
        h_wr_addr = '0; h_wr_data = '0; h_br = 8'hFF;
        d_st = 0; d_cnt = 0; d_nobusy = 0; d_force0 = 0; d_busy = 0; d_done = 0;
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; enable = 0;
        brightness = 8'hFF; drv_busy = 0; drv_done = 0; rd_addr = '0;
        model_reset();
        run_cycles(3);
        h_rst = 0;

        // frame store: 0xA5 at addr 0 reaches the driver after the first swap
        h_wr_en = 1; h_wr_addr = '0; h_wr_data = 8'hA5;
        step();
        h_commit = 1;
        step();
        h_enable = 1;
        d_force0 = 1;
        c0 = cyc + 1;
        wait_start(FRAME_TCK + 50, "first_start");
        check_eq("first_latency", 32'(cyc - c0), FRAME_TCK + 1);
        check_eq("front_after_start", front_bank, 1);
        step();
        step();
        check_eq("a5_readback", drv_data, 8'hA5);
        d_force0 = 0;

        // random host traffic and refresh
        h_rand = 1;
        run_cycles(15 * FRAME_TCK);
        h_rand = 0; h_wr_en = 0; h_commit = 0; h_br = 8'hFF;

        // commit during SEND must not swap until the next start
        wait_start(FRAME_TCK + 50, "tu_start");
        wait_phase(2, 100, "tu_send");
        f0 = front_bank;
        h_commit = 1;
        step();
        step();
        check_eq("pend_in_send", swap_pending, 1);
        held = 1;
        n = 0;
        while (!drv_start && n < FRAME_TCK + 50 && errors <= 40) begin
            if (front_bank !== f0[0]) held = 0;
            step();
            n++;
        end
        check_eq("front_held", held, 1);
        check_eq("swap_at_start", front_bank, !f0[0]);

        // two commits between frames: one error, one toggle
        wait_phase(0, 200, "ov_idle");
        run_cycles(10);
        f0 = front_bank;
        e0 = err_seen;
        h_commit = 1;
        step();
        h_commit = 1;
        step();
        wait_start(FRAME_TCK + 50, "ov_start");
        check_eq("overrun_errs", 32'(err_seen - e0), 1);
        check_eq("overrun_toggle", front_bank, !f0[0]);
        check_eq("overrun_pend_clr", swap_pending, 0);

        // driver never raises busy
        d_nobusy = 1;
        wait_start(FRAME_TCK + 50, "tmo_start");
        sc = cyc;
        n = 0;
        while (!err && n < 10 && errors <= 40) begin step(); n++; end
        check_eq("tmo_latency", 32'(cyc - sc), START_TMO);
        wait_start(FRAME_TCK + 50, "tmo_restart");

        // enable drops mid-frame: frame completes, no further start
        wait_phase(2, 100, "en_send");
        fc0 = frame_cnt;
        n = start_seen;
        h_enable = 0;
        run_cycles(2 * FRAME_TCK + 500);
        check_eq("no_start_disabled", 32'(start_seen - n), 0);
        check_eq("frame_completed", frame_cnt, 16'(fc0 + 1));
        h_enable = 1;
        wait_start(FRAME_TCK + 50, "re_enable");

        // asynchronous reset while sending
        wait_phase(2, 100, "rst_send");
        step();
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check_eq("rst_start", drv_start, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_front", front_bank, 0);
        check_eq("rst_pend", swap_pending, 0);
        check_eq("rst_cnt", frame_cnt, 0);
        check_eq("rst_data", drv_data, 0);
        h_rst = 1;
        model_reset();
        d_st = 0; d_busy = 0; d_done = 0;
        run_cycles(3);
        h_rst = 0;
        wait_start(FRAME_TCK + 50, "post_rst_start");
        run_cycles(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
